// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic blocks.
//   ser_state_t : controller states (IDLE, RUN, DONE)
//   cnt_width() : width of the bit counter that walks WIDTH operand bits
// -----------------------------------------------------------------------------
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ser_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit full-subtractor cell, purely combinational: computes a - b - bin.
//   a, b  : minuend / subtrahend bit
//   bin   : borrow in from the less significant bit
//   d     : difference bit
//   bout  : borrow out to the more significant bit
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial, LSB-first two's-complement subtractor: diff = a - b (WIDTH bits).
// A single full_subtractor cell plus a borrow flop is reused for WIDTH cycles.
//   clk, rst            : clock, asynchronous active-high reset
//   start_valid/ready   : operand handshake; operands sampled on the accept edge
//   a, b                : minuend, subtrahend
//   result_valid/ready  : result handshake; result held while valid
//   diff                : a - b mod 2^WIDTH
//   borrow_out          : unsigned borrow (a < b as unsigned)
//   overflow            : signed overflow of a - b
// Timing: result_valid rises WIDTH cycles after the accept edge.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = cnt_width(WIDTH);

  ser_state_t       state_q,      state_d;
  logic [WIDTH-1:0] a_sh_q,       a_sh_d;
  logic [WIDTH-1:0] b_sh_q,       b_sh_d;
  logic [WIDTH-1:0] diff_sh_q,    diff_sh_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             borrow_q,     borrow_d;
  logic             sign_a_q,     sign_a_d;
  logic             sign_b_q,     sign_b_d;
  logic [WIDTH-1:0] diff_q,       diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q,   overflow_d;

  logic cell_d;
  logic cell_bout;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    // NOTE: every next-state signal gets a hold default before the case so no
    // path through this block leaves a value unassigned and infers a latch.
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    diff_sh_d    = diff_sh_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    sign_a_d     = sign_a_q;
    sign_b_d     = sign_b_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1];
          state_d  = RUN;
        end
      end

      RUN: begin
        diff_sh_d = {cell_d, diff_sh_q[WIDTH-1:1]};
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        borrow_d  = cell_bout;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Last cell evaluation is the MSB: both flags come straight from it.
          state_d      = DONE;
          diff_d       = {cell_d, diff_sh_q[WIDTH-1:1]};
          borrow_out_d = cell_bout;
          overflow_d   = (sign_a_q != sign_b_q) && (cell_d != sign_a_q);
        end
      end

      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_sh_q    <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      diff_sh_q    <= diff_sh_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  // Handshake outputs decode from the state register only.
  assign start_ready  = (state_q == IDLE);
  assign result_valid = (state_q == DONE);
  assign diff         = diff_q;
  assign borrow_out   = borrow_out_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=8). Expected results are
// queued when operands are driven and popped when result_valid is seen.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 50;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .diff         (diff),
    .borrow_out   (borrow_out),
    .overflow     (overflow)
  );

  // Reference arithmetic: two's-complement subtract with unsigned borrow and
  // signed overflow.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    exp_t e;
    e.diff   = av - bv;
    e.borrow = (av < bv);
    e.ovf    = (av[WIDTH-1] != bv[WIDTH-1]) && (e.diff[WIDTH-1] != av[WIDTH-1]);
    return e;
  endfunction

  // Presents operands, waits for the accept edge and returns on the falling
  // edge right after it.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input exp_t e);
    int waited = 0;
    @(negedge clk);
    while (start_ready !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready_wait: got %b want 1", start_ready);
    end
    a = av;
    b = bv;
    start_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (start_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_start_ready: got %b want 0", start_ready);
    end
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Called on the falling edge after the accept edge; counts rising edges
  // until result_valid and checks latency and payload.
  task automatic wait_result();
    int   cyc = 0;
    exp_t e;
    while (cyc < TIMEOUT) begin
      @(posedge clk);
      #1;
      cyc++;
      if (result_valid === 1'b1) break;
    end
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout: result_valid=%b after %0d cycles", result_valid, cyc);
      return;
    end
    checks++;
    if (cyc !== WIDTH) begin
      errors++;
      $display("FAIL latency: got %0d cycles want %0d", cyc, WIDTH);
    end
    checks++;
    if (start_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_start_ready: got %b want 0", start_ready);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: result with no expectation");
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (diff !== e.diff) begin
      errors++;
      $display("FAIL diff: got %h want %h", diff, e.diff);
    end
    checks++;
    if (borrow_out !== e.borrow) begin
      errors++;
      $display("FAIL borrow_out: got %b want %b (diff %h)", borrow_out, e.borrow, e.diff);
    end
    checks++;
    if (overflow !== e.ovf) begin
      errors++;
      $display("FAIL overflow: got %b want %b (diff %h)", overflow, e.ovf, e.diff);
    end
    if (result_ready === 1'b1) begin
      @(posedge clk);
      #1;
      checks++;
      if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
        errors++;
        $display("FAIL done_exit: result_valid=%b start_ready=%b want 0/1", result_valid, start_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    a            = '0;
    b            = '0;
    #1 rst = 1'b1;
    #11;
    checks++;
    if (result_valid !== 1'b0 || diff !== '0 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b diff=%h borrow=%b ovf=%b want all 0",
               result_valid, diff, borrow_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: start_ready=%b result_valid=%b want 1/0", start_ready, result_valid);
    end
  endtask

  // Directed vectors with hand-derived results; the last leaves nonzero
  // outputs behind for the mid-run reset test.
  task automatic test_basic();
    logic [WIDTH-1:0] va [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
    logic [WIDTH-1:0] vb [5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
    logic [WIDTH-1:0] vd [5] = '{8'h02, 8'hFE, 8'h00, 8'h7F, 8'h80};
    logic             vbo[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic             vov[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    result_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], '{diff: vd[i], borrow: vbo[i], ovf: vov[i]});
      wait_result();
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (result_valid !== 1'b0 || diff !== '0 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: valid=%b diff=%h borrow=%b ovf=%b want all 0",
               result_valid, diff, borrow_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset_idle: start_ready=%b want 1", start_ready);
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (result_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_pulse: result_valid seen=%b want 0", saw_valid);
    end
    start_op(8'h09, 8'h04, '{diff: 8'h05, borrow: 1'b0, ovf: 1'b0});
    wait_result();
  endtask

  task automatic test_operand_change();
    result_ready = 1'b1;
    start_op(8'h10, 8'h01, '{diff: 8'h0F, borrow: 1'b0, ovf: 1'b0});
    a = 8'hFF;
    b = 8'hFF;
    wait_result();
  endtask

  task automatic test_back_pressure();
    logic [WIDTH-1:0] held;
    result_ready = 1'b0;
    start_op(8'h5A, 8'h33, model(8'h5A, 8'h33));
    wait_result();
    held = diff;
    @(negedge clk);
    a = 8'h01;
    b = 8'h01;
    start_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (result_valid !== 1'b1 || diff !== held || start_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b diff=%h start_ready=%b want 1/%h/0",
                 i, result_valid, diff, start_ready, held);
      end
    end
    @(negedge clk);
    result_ready = 1'b1;
    sb_q.push_back('{diff: 8'h00, borrow: 1'b0, ovf: 1'b0});
    @(posedge clk);
    #1;
    checks++;
    if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: start_ready=%b result_valid=%b want 1/0", start_ready, result_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (start_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_accept: start_ready=%b want 0", start_ready);
    end
    @(negedge clk);
    start_valid = 1'b0;
    wait_result();
  endtask

  // start_valid held high across two operations: second accept must land
  // exactly WIDTH+2 edges after the first.
  task automatic test_back_to_back();
    int   edges = 0;
    bit   seen  = 1'b0;
    bit   sr;
    exp_t e;
    result_ready = 1'b1;
    @(negedge clk);
    a = 8'h2A;
    b = 8'h15;
    start_valid = 1'b1;
    sb_q.push_back(model(8'h2A, 8'h15));
    @(posedge clk);
    @(negedge clk);
    a = 8'h15;
    b = 8'h2A;
    sb_q.push_back(model(8'h15, 8'h2A));
    while (edges < TIMEOUT) begin
      sr = start_ready;
      if (result_valid === 1'b1 && !seen) begin
        seen = 1'b1;
        checks++;
        if (start_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_done_ready: start_ready=%b want 0", start_ready);
        end
        e = sb_q.pop_front();
        checks++;
        if (diff !== e.diff || borrow_out !== e.borrow || overflow !== e.ovf) begin
          errors++;
          $display("FAIL b2b_first_result: got %h/%b/%b want %h/%b/%b",
                   diff, borrow_out, overflow, e.diff, e.borrow, e.ovf);
        end
      end
      @(posedge clk);
      edges++;
      if (sr) break;
      @(negedge clk);
    end
    checks++;
    if (edges !== WIDTH + 2 || !seen) begin
      errors++;
      $display("FAIL b2b_throughput: second accept after %0d edges (result seen=%b) want %0d",
               edges, seen, WIDTH + 2);
    end
    @(negedge clk);
    start_valid = 1'b0;
    wait_result();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    result_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = WIDTH'($urandom_range(0, 255));
      start_op(ra, rb, model(ra, rb));
      wait_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_run();
    test_operand_change();
    test_back_pressure();
    test_back_to_back();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first two's-complement subtractor: diff = a - b over WIDTH bits.
- Complements the team's combinational adder cells: one 1-bit full-subtractor cell plus a borrow flip-flop, reused for WIDTH cycles.
- Area-minimal arithmetic for slow control paths.
- Valid/ready on both the operand side and the result side.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- start_valid  input  1  operands a and b are presented.
- start_ready  output  1  block accepts operands; high only in IDLE.
- a  input  WIDTH  minuend; sampled only on the accept edge.
- b  input  WIDTH  subtrahend; sampled only on the accept edge.
- result_valid  output  1  diff, borrow_out and overflow are valid; high only in DONE.
- result_ready  input  1  consumer takes the result.
- diff  output  WIDTH  a - b mod 2^WIDTH.
- borrow_out  output  1  unsigned borrow; 1 iff a < b as unsigned.
- overflow  output  1  signed overflow of a - b.

Behaviour:
- Reset values: state=IDLE; start_ready=1 once rst deasserts; result_valid=0; diff=0; borrow_out=0; overflow=0; internal shift registers, borrow and bit counter = 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start_ready=1.
  - Accept on a rising edge with start_valid=1: load a_sh<=a, b_sh<=b, borrow<=0, cnt<=0, latch sign_a=a[WIDTH-1] and sign_b=b[WIDTH-1], then go to RUN.
- RUN:
  - start_ready=0, result_valid=0.
  - Each edge: cell inputs are a_sh[0], b_sh[0], borrow.
  - d = a^b^bin; bout = (~a&b) | (~a&bin) | (b&bin).
  - diff_sh <= {d, diff_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; borrow <= bout; cnt++.
  - On the edge where cnt==WIDTH-1: go to DONE.
  - On that same edge, register borrow_out=bout and overflow=(sign_a!=sign_b) && (d!=sign_a).
- DONE:
  - result_valid=1; diff, borrow_out and overflow are held stable.
  - On an edge with result_ready=1, go to IDLE.
  - Outputs keep their last value after leaving DONE; they are only meaningful while result_valid=1.
- Latency:
  - result_valid rises exactly WIDTH cycles after the accept edge.
  - Throughput is one operation per WIDTH+2 cycles with result_ready held high. No back-to-back overlap.
- Handshake rules:
  - Operands are ignored outside IDLE; a and b may change freely after the accept edge.
  - result_ready is ignored outside DONE.
  - start_valid in the same cycle DONE exits is not accepted; start_ready is 0 in DONE, so acceptance happens at the earliest on the next cycle, from IDLE.
  - No combinational path from any input to any output: start_ready and result_valid decode from the state register only.
- Back-pressure: DONE persists indefinitely while result_ready=0; outputs are stable.
- Reset mid-operation: rst in RUN or DONE returns to IDLE asynchronously, clears outputs and discards any in-flight result. No result_valid pulse follows.
- Arithmetic:
  - cnt width is $clog2(WIDTH).
  - Borrow chain is unsigned; overflow is the signed interpretation.
  - Both flags are derived from the final cell evaluation, not recomputed.

Decomposition:
- Package serial_arith_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} ser_state_t
  - function cnt_width(WIDTH) returning $clog2(WIDTH)
- Sub-module full_subtractor: ports a, b, bin, d, bout; purely combinational; instantiated once.
- Top level contains the FSM, shift registers, counter and output registers.

Test Plan (WIDTH=8):
- a=0x05, b=0x03, result_ready=1 → result_valid exactly 8 cycles after accept; diff=0x02, borrow_out=0, overflow=0.
- a=0x03, b=0x05 → diff=0xFE, borrow_out=1, overflow=0; a=0x00, b=0x00 → diff=0x00, flags 0.
- a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1; a=0x7F, b=0xFF → diff=0x80, borrow_out=1, overflow=1.
- Back-pressure: hold result_ready=0 for 20 cycles → result_valid and diff stable, start_ready=0 throughout, a second start_valid is not accepted. Release → IDLE next cycle, then accept.
- Operand change: after the accept of 0x10-0x01, drive a=0xFF, b=0xFF during RUN → diff=0x0F, unaffected.
- Reset in RUN at cnt=4 → outputs 0 and state IDLE immediately. No result_valid pulse. The next operation 0x09-0x04 gives diff=0x05.
